button_event_encoder: RTL and testbench
=======================================

BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

Interface
REQ-001 Parameter N_BTN, default 12: number of button pulse lines consumed.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue entries; power of two, range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_pulse  input  N_BTN  one-cycle debounced press pulses from the controller's controller_output.
REQ-006 cmd_ready  input  1  consumer accepts the head command this cycle.
REQ-007 clear_overflow  input  1  synchronous clear of the overflow flag.
REQ-008 cmd_valid  output  1  queue non-empty; cmd_code is valid.
REQ-009 cmd_code  output  4  button index (0..N_BTN-1) of the head event.
REQ-010 block_controller  output  1  back-pressure to the controller's block_controller input.
REQ-011 overflow  output  1  sticky flag: a press event was dropped.
REQ-012 pending_count  output  clog2(FIFO_DEPTH+1)  number of queued events.

Function
REQ-013 An event SHALL be generated in a cycle where btn_pulse != 0.
- Code = lowest set bit index (priority encode).
- Higher set bits that cycle are discarded and do not set overflow.
REQ-014 Events SHALL enter a FIFO_DEPTH-entry first-word-fall-through queue.
- Push takes effect at the clock edge.
- The pushed code is visible on cmd_code on the next cycle when the queue was empty.
- Latency from btn_pulse to cmd_valid is exactly 1 cycle.
REQ-015 cmd_valid SHALL equal (pending_count != 0).
- cmd_code SHALL show the oldest entry.
- cmd_code SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-016 A pop SHALL occur on cmd_valid & cmd_ready; cmd_ready with cmd_valid=0 has no effect.
REQ-017 Simultaneous push and pop SHALL both take effect.
- pending_count is unchanged.
- This also applies when the queue is full: the push is accepted.
REQ-018 Push into a full queue without a pop SHALL be dropped and SHALL set overflow.
- Queue contents and pending_count are unchanged.
REQ-019 overflow SHALL remain 1 until clear_overflow=1.
- If a drop and clear_overflow occur in the same cycle, overflow is 1 after the edge (set wins).
REQ-020 Read and write pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH without skipping entries.
REQ-021 block_controller SHALL be registered, with value (next pending_count >= FIFO_DEPTH-1).
- It asserts one slot before full, absorbing the controller's one-cycle reaction delay.
REQ-022 Ordering SHALL be strict FIFO; no event is duplicated or reordered.

Reset
REQ-023 While reset=0, SHALL force the following, asynchronously:
- pending_count=0, cmd_valid=0, cmd_code=0
- block_controller=0, overflow=0
- pointers=0
REQ-024 Reset asserted mid-operation SHALL discard all queued events.
- The first cycle after reset release behaves as an empty queue.
- A btn_pulse present in the release cycle is accepted normally.

Verification
REQ-025 Reset release, btn_pulse=12'h010 for one cycle, cmd_ready=0 -> next cycle:
- cmd_valid=1, cmd_code=4, pending_count=1
- values held indefinitely.
REQ-026 btn_pulse=12'h0A0 for one cycle -> single event, cmd_code=5, overflow=0.
REQ-027 Five consecutive pulses on bits 0,1,2,3,4 with cmd_ready=0, FIFO_DEPTH=4:
- block_controller=1 after the 3rd push
- pending_count=4, overflow=1 after the 5th
- pops return 0,1,2,3.
REQ-028 Full queue, push bit 7 and cmd_ready=1 in the same cycle:
- code 0 popped, pending_count stays 4, overflow unchanged
- subsequent pops return 1,2,3,7.
REQ-029 Three events queued, reset pulsed low mid-cycle (asynchronous) -> outputs zero immediately, no stale codes after release.
REQ-030 overflow=1, then clear_overflow=1 together with a dropped push -> overflow=1; clear_overflow=1 alone next cycle -> overflow=0.

Source files
------------

// File: rtl/button_event_encoder.sv
// button_event_encoder
// Turns one-cycle button press pulses into 4-bit button codes. The codes are
// held in a small first-word-fall-through queue that a command consumer drains
// with a valid/ready handshake. The queue raises back-pressure one slot before
// it is full. A sticky overflow flag records any press that had to be dropped.
module button_event_encoder #(
    parameter int N_BTN      = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic             cmd_ready,
    input  logic             clear_overflow,
    output logic             cmd_valid,
    output logic [3:0]       cmd_code,
    output logic             block_controller,
    output logic             overflow,
    output logic [CW-1:0]    pending_count
);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_BLOCK = CW'(FIFO_DEPTH - 1);

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_block;
    logic          r_overflow;

    logic [3:0]    w_code;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr_en;
    logic          w_drop;
    logic [CW-1:0] w_count_next;

    // Priority encode: the lowest set pulse bit wins, and higher bits are ignored.
    always_comb begin
        w_code = 4'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn_pulse[i]) begin
                w_code = 4'(i);
            end
        end
    end

    // Queue control. When a pop and a push happen in the same cycle, a full
    // queue still accepts the push.
    always_comb begin
        w_push       = |btn_pulse;
        w_pop        = (r_count != '0) && cmd_ready;
        w_full       = (r_count == CNT_FULL);
        w_wr_en      = w_push && (!w_full || w_pop);
        w_drop       = w_push && w_full && !w_pop;
        w_count_next = r_count + CW'(w_wr_en) - CW'(w_pop);
    end

    // Event storage. This block has no reset, so it can map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    // Pointers, occupancy, registered back-pressure and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_block    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
            r_block <= (w_count_next >= CNT_BLOCK);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // The head code is gated by valid, so reset forces it to zero whatever the storage holds.
    always_comb begin
        cmd_valid        = (r_count != '0);
        cmd_code         = cmd_valid ? r_mem[r_rd_ptr] : 4'd0;
        block_controller = r_block;
        overflow         = r_overflow;
        pending_count    = r_count;
    end

endmodule

// File: tb/tb_button_event_encoder.sv
// Testbench for button_event_encoder (N_BTN=12, FIFO_DEPTH=4).
// The first part applies a table of directed vectors. Hand-written sequences
// then cover asynchronous reset. The last part drives random stimulus and
// compares the outputs against a queue-based reference model.
module tb_button_event_encoder;

    localparam int NB = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_pulse;
    logic          cmd_ready;
    logic          clear_overflow;
    logic          cmd_valid;
    logic [3:0]    cmd_code;
    logic          block_controller;
    logic          overflow;
    logic [2:0]    pending_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    button_event_encoder #(.N_BTN(NB), .FIFO_DEPTH(FD)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_pulse        (btn_pulse),
        .cmd_ready        (cmd_ready),
        .clear_overflow   (clear_overflow),
        .cmd_valid        (cmd_valid),
        .cmd_code         (cmd_code),
        .block_controller (block_controller),
        .overflow         (overflow),
        .pending_count    (pending_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] pulse;
        logic          ready;
        logic          clr;
        logic          ev;
        logic [3:0]    ec;
        logic [2:0]    en;
        logic          eb;
        logic          eo;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ev, input int ec, input int en,
                           input int eb, input int eo);
        chk({tag, " valid"}, int'(cmd_valid), ev);
        if (ev != 0) chk({tag, " code"}, int'(cmd_code), ec);
        chk({tag, " count"}, int'(pending_count), en);
        chk({tag, " block"}, int'(block_controller), eb);
        chk({tag, " ovf"}, int'(overflow), eo);
    endtask

    // Reference model: a plain queue of button indices plus a flag.
    int  m_q[$];
    bit  m_ovf;

    function automatic int lowest_bit(input int p);
        return $clog2(p & -p);
    endfunction

    task automatic model_step(input int p, input bit rdy, input bit clr);
        bit dropped = 0;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (p != 0) begin
            if (m_q.size() < FD) m_q.push_back(lowest_bit(p));
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    initial begin
        // pulse, ready, clr -> valid, code, count, block, ovf after the edge
        vecs[0]  = '{12'h010, 0, 0, 1, 4, 1, 0, 0};
        vecs[1]  = '{12'h000, 0, 0, 1, 4, 1, 0, 0};
        vecs[2]  = '{12'h000, 0, 0, 1, 4, 1, 0, 0};
        vecs[3]  = '{12'h000, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{12'h0A0, 0, 0, 1, 5, 1, 0, 0};
        vecs[5]  = '{12'h000, 1, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{12'h000, 1, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{12'h001, 0, 0, 1, 0, 1, 0, 0};
        vecs[8]  = '{12'h002, 0, 0, 1, 0, 2, 0, 0};
        vecs[9]  = '{12'h004, 0, 0, 1, 0, 3, 1, 0};
        vecs[10] = '{12'h008, 0, 0, 1, 0, 4, 1, 0};
        vecs[11] = '{12'h010, 0, 0, 1, 0, 4, 1, 1};
        vecs[12] = '{12'h080, 1, 0, 1, 1, 4, 1, 1};
        vecs[13] = '{12'h000, 1, 0, 1, 2, 3, 1, 1};
        vecs[14] = '{12'h000, 1, 0, 1, 3, 2, 0, 1};
        vecs[15] = '{12'h000, 1, 0, 1, 7, 1, 0, 1};
        vecs[16] = '{12'h000, 1, 0, 0, 0, 0, 0, 1};
        vecs[17] = '{12'h001, 0, 0, 1, 0, 1, 0, 1};
        vecs[18] = '{12'h002, 0, 0, 1, 0, 2, 0, 1};
        vecs[19] = '{12'h004, 0, 0, 1, 0, 3, 1, 1};
        vecs[20] = '{12'h008, 0, 0, 1, 0, 4, 1, 1};
        vecs[21] = '{12'h010, 0, 1, 1, 0, 4, 1, 1};
        vecs[22] = '{12'h000, 0, 1, 1, 0, 4, 1, 0};

        reset = 1'b0;
        btn_pulse = '0;
        cmd_ready = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) tick();
        chk("reset code", int'(cmd_code), 0);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            btn_pulse      = vecs[i].pulse;
            cmd_ready      = vecs[i].ready;
            clear_overflow = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].ev), int'(vecs[i].ec),
                    int'(vecs[i].en), int'(vecs[i].eb), int'(vecs[i].eo));
            $display("vec %0d: pulse=%03h rdy=%0d clr=%0d -> valid=%0d code=%0d cnt=%0d blk=%0d ovf=%0d",
                     i, vecs[i].pulse, vecs[i].ready, vecs[i].clr, cmd_valid, cmd_code,
                     pending_count, block_controller, overflow);
        end

        // Asynchronous reset in mid-cycle while the queue holds entries.
        btn_pulse = '0; cmd_ready = 1'b1; clear_overflow = 1'b0;
        tick();
        cmd_ready = 1'b0;
        chk("pre-reset count", int'(pending_count), 3);
        #2 reset = 1'b0;
        #1;
        chk("async reset code", int'(cmd_code), 0);
        chk_all("async reset", 0, 0, 0, 0, 0);
        tick();
        chk_all("reset held", 0, 0, 0, 0, 0);
        // Release, with a press already present in the release cycle.
        reset = 1'b1;
        btn_pulse = 12'h400;
        tick();
        btn_pulse = '0;
        chk_all("release push", 1, 10, 1, 0, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk_all("no stale", 0, 0, 0, 0, 0);
        $display("reset sequence done: valid=%0d cnt=%0d", cmd_valid, pending_count);

        // Randomized stimulus against the reference model.
        m_q.delete();
        m_ovf = 0;
        for (int c = 0; c < 3000; c++) begin
            int p;
            bit rdy, clr;
            p = 0;
            if ($urandom_range(0, 2) != 0) begin
                p = 1 << $urandom_range(0, NB - 1);
                if ($urandom_range(0, 3) == 0) p = p | int'($urandom() & 32'hFFF);
            end
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 15) == 0);
            btn_pulse = p[NB-1:0];
            cmd_ready = rdy;
            clear_overflow = clr;
            model_step(p, rdy, clr);
            tick();
            chk_all($sformatf("rnd%0d", c), int'(m_q.size() != 0),
                    (m_q.size() != 0) ? m_q[0] : 0, m_q.size(),
                    int'(m_q.size() >= FD - 1), int'(m_ovf));
        end
        btn_pulse = '0; cmd_ready = 1'b0; clear_overflow = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
